// File: rtl/buffer_read_sequencer_if.sv
// Bundles the command, bank read-port and output stream signals of the save-path
// read sequencer; master is the sequencer side, slave is its environment.
interface buffer_read_sequencer_if #(
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int LEN_WIDTH         = 12
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [BUFFER_ADDR_WIDTH-1:0] cmd_base_addr;
    logic [LEN_WIDTH-1:0]         cmd_len;
    logic                         buf_read_addr_valid;
    logic [BUFFER_ADDR_WIDTH-1:0] buf_read_addr;
    logic                         buf_read_data_valid;
    logic [BUFFER_DATA_WIDTH-1:0] buf_read_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [BUFFER_DATA_WIDTH-1:0] out_data;
    logic                         out_last;
    logic                         busy;
    logic                         done;

    modport master (
        input  cmd_valid, cmd_base_addr, cmd_len,
        output cmd_ready,
        output buf_read_addr_valid, buf_read_addr,
        input  buf_read_data_valid, buf_read_data,
        output out_valid, out_data, out_last,
        input  out_ready,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_base_addr, cmd_len,
        input  cmd_ready,
        input  buf_read_addr_valid, buf_read_addr,
        output buf_read_data_valid, buf_read_data,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  busy, done
    );
endinterface

// File: rtl/buffer_read_sequencer.sv
// Credit-throttled burst reader: issues bank line reads for a (base, len) command and
// streams the fixed-latency returns through a small FIFO with a registered head.
module buffer_read_sequencer_chk #(
    parameter int CW         = 4,
    parameter int FIFO_DEPTH = 8,
    parameter bit DEPTH_OK   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    a_depth_ok: assert property (@(posedge clk) disable iff (rst) DEPTH_OK);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == DEPTH_C)));
endmodule

module buffer_read_sequencer #(
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int LEN_WIDTH         = 12,
    parameter int FIFO_DEPTH        = 8,
    parameter int READ_LATENCY      = 4
) (
    input logic                     clk,
    input logic                     rst,
    buffer_read_sequencer_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]                DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]                CNT_ZERO  = {CW{1'b0}};
    localparam logic [PW-1:0]                PTR_ONE   = PW'(1);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] ADDR_ONE  = BUFFER_ADDR_WIDTH'(1);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] ADDR_ZERO = {BUFFER_ADDR_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]         LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]         LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [BUFFER_DATA_WIDTH-1:0] DATA_ZERO = {BUFFER_DATA_WIDTH{1'b0}};
    localparam bit                           DEPTH_OK  = (FIFO_DEPTH >= READ_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                       state_r, state_nxt_s;
    logic                         cmd_ready_r, busy_r, done_r, done_nxt_s;
    logic                         addr_valid_r;
    logic [BUFFER_ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]         len_r, issued_r, delivered_r;
    logic [LEN_WIDTH-1:0]         issued_nxt_s, delivered_nxt_s;
    logic [CW-1:0]                inflight_r, count_r;
    logic [CW-1:0]                inflight_nxt_s, count_nxt_s, credit_nxt_s, mem_cnt_s;
    logic [PW-1:0]                wr_ptr_r, rd_ptr_r;
    logic [BUFFER_DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic                         out_valid_r, out_last_r;
    logic [BUFFER_DATA_WIDTH-1:0] out_data_r;
    logic                         accept_s, issue_s, push_s, pop_s;
    logic                         head_free_s, load_mem_s, load_byp_s, mem_wr_s, last_nxt_s;

    // Handshake qualifiers, occupancy bookkeeping and next-cycle credit.
    always_comb begin
        accept_s        = bus.cmd_valid && cmd_ready_r;
        issue_s         = addr_valid_r;
        // Returns with nothing outstanding belong to a burst killed by reset.
        push_s          = bus.buf_read_data_valid && (inflight_r != CNT_ZERO);
        pop_s           = out_valid_r && bus.out_ready;
        head_free_s     = !out_valid_r || pop_s;
        mem_cnt_s       = count_r - CW'(out_valid_r);
        load_mem_s      = head_free_s && (mem_cnt_s != CNT_ZERO);
        load_byp_s      = head_free_s && (mem_cnt_s == CNT_ZERO) && push_s;
        mem_wr_s        = push_s && !load_byp_s;
        inflight_nxt_s  = inflight_r + CW'(issue_s) - CW'(push_s);
        count_nxt_s     = count_r + CW'(push_s) - CW'(pop_s);
        credit_nxt_s    = DEPTH_C - count_nxt_s - inflight_nxt_s;
        issued_nxt_s    = issued_r + LEN_WIDTH'(issue_s);
        delivered_nxt_s = delivered_r + LEN_WIDTH'(pop_s);
        last_nxt_s      = ((delivered_nxt_s + LEN_ONE) == len_r);
    end

    // Next-state and done-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.cmd_len == LEN_ZERO) begin
                        state_nxt_s = ST_IDLE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issued_nxt_s == len_r) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (delivered_nxt_s == len_r) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cmd_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            addr_valid_r <= 1'b0;
            inflight_r   <= CNT_ZERO;
        end else begin
            state_r      <= state_nxt_s;
            cmd_ready_r  <= (state_nxt_s == ST_IDLE);
            busy_r       <= (state_nxt_s != ST_IDLE);
            done_r       <= done_nxt_s;
            addr_valid_r <= (state_nxt_s == ST_ISSUE) && (credit_nxt_s != CNT_ZERO);
            inflight_r   <= inflight_nxt_s;
        end
    end

    // Command latch, read address generation and progress counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r      <= ADDR_ZERO;
            len_r       <= LEN_ZERO;
            issued_r    <= LEN_ZERO;
            delivered_r <= LEN_ZERO;
        end else if (accept_s) begin
            addr_r      <= bus.cmd_base_addr;
            len_r       <= bus.cmd_len;
            issued_r    <= LEN_ZERO;
            delivered_r <= LEN_ZERO;
        end else begin
            if (issue_s) begin
                addr_r <= addr_r + ADDR_ONE;
            end
            issued_r    <= issued_nxt_s;
            delivered_r <= delivered_nxt_s;
        end
    end

    // Return-line storage behind the head register.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem_r[wr_ptr_r] <= bus.buf_read_data;
        end
    end

    // FIFO pointers, occupancy and the registered stream head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
            out_data_r  <= DATA_ZERO;
            out_last_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (mem_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_mem_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= mem_r[rd_ptr_r];
                out_last_r  <= last_nxt_s;
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
            end else if (load_byp_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= bus.buf_read_data;
                out_last_r  <= last_nxt_s;
            end else if (head_free_s) begin
                out_valid_r <= 1'b0;
                out_data_r  <= DATA_ZERO;
                out_last_r  <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready           = cmd_ready_r;
    assign bus.buf_read_addr_valid = addr_valid_r;
    assign bus.buf_read_addr       = addr_r;
    assign bus.out_valid           = out_valid_r;
    assign bus.out_data            = out_data_r;
    assign bus.out_last            = out_last_r;
    assign bus.busy                = busy_r;
    assign bus.done                = done_r;

    buffer_read_sequencer_chk #(
        .CW         (CW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DEPTH_OK   (DEPTH_OK)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
endmodule

// File: tb/tb_buffer_read_sequencer.sv
// Directed and randomized bench for buffer_read_sequencer: a latency-4 bank model feeds
// the DUT and observed addresses/beats are compared against per-command expectations.
module tb_buffer_read_sequencer;
    localparam int AW = 11, DW = 512, LW = 12, DEPTH = 8, RL = 4;
    localparam int NLINES = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buffer_read_sequencer_if #(.BUFFER_ADDR_WIDTH(AW), .BUFFER_DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    buffer_read_sequencer #(
        .BUFFER_ADDR_WIDTH (AW), .BUFFER_DATA_WIDTH (DW), .LEN_WIDTH (LW),
        .FIFO_DEPTH (DEPTH), .READ_LATENCY (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bank contents and fixed-latency read pipe (keeps running through DUT reset).
    logic [DW-1:0] bank_mem [NLINES];
    bit            pv [RL];
    bit [AW-1:0]   pa [RL];
    always @(posedge clk) begin
        pv[0] <= bus.buf_read_addr_valid;
        pa[0] <= bus.buf_read_addr;
        for (int i = 1; i < RL; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign bus.buf_read_data_valid = pv[RL-1];
    assign bus.buf_read_data       = pv[RL-1] ? bank_mem[pa[RL-1]] : {DW{1'b0}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the DUT, sampled mid-cycle.
    logic [AW-1:0] addr_q[$];
    int            addr_cyc_q[$];
    logic [DW-1:0] beat_q[$];
    bit            last_q[$];
    int            beat_cyc_q[$];
    int            done_cnt = 0, done_cyc = -1;
    int            stab_err = 0, zero_err = 0, outstanding = 0, max_out = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (bus.buf_read_addr_valid) begin
                addr_q.push_back(bus.buf_read_addr);
                addr_cyc_q.push_back(cyc);
                outstanding++;
            end
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
                stab_err++;
            if (!bus.out_valid && (bus.out_data !== {DW{1'b0}} || bus.out_last !== 1'b0))
                zero_err++;
            if (bus.out_valid && bus.out_ready) begin
                beat_q.push_back(bus.out_data);
                last_q.push_back(bus.out_last);
                beat_cyc_q.push_back(cyc);
                outstanding--;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int at_i(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        addr_q.delete(); addr_cyc_q.delete();
        beat_q.delete(); last_q.delete(); beat_cyc_q.delete();
        max_out = 0; stab_err = 0; zero_err = 0;
    endtask

    // Returns the accept cycle; leaves the bench one cycle after acceptance.
    task automatic send_cmd(input int base, input int len, output int t);
        int k;
        k = 0;
        bus.cmd_valid     = 1'b1;
        bus.cmd_base_addr = AW'(base);
        bus.cmd_len       = LW'(len);
        while (!bus.cmd_ready && k < 50) begin
            step();
            k++;
        end
        chk("cmd_accept", bus.cmd_ready, 1);
        t = cyc;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, input bit rand_ready, input int start_cnt);
        int k;
        k = 0;
        while (done_cnt == start_cnt && k < max) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            k++;
        end
        chk("done_timeout", (done_cnt != start_cnt), 1);
        bus.out_ready = 1'b1;
    endtask

    // Expected stream: lines base..base+len-1 modulo bank size, last flag on the final one.
    task automatic check_cmd(input string tag, input int base, input int len);
        int a;
        chk({tag, " n_addr"}, addr_q.size(), len);
        chk({tag, " n_beat"}, beat_q.size(), len);
        for (int i = 0; i < len && i < addr_q.size() && i < beat_q.size(); i++) begin
            a = (base + i) % NLINES;
            chk($sformatf("%s addr[%0d]", tag, i), addr_q[i], a);
            chk($sformatf("%s data[%0d]", tag, i), beat_q[i], bank_mem[a]);
            chk($sformatf("%s last[%0d]", tag, i), last_q[i], (i == len - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, dc, b;
        for (int a = 0; a < NLINES; a++)
            for (int w = 0; w < DW / 32; w++)
                bank_mem[a][w*32 +: 32] = $urandom();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_base_addr = '0; bus.cmd_len = '0; bus.out_ready = 1'b1;
        #2;
        chk("reset_ctrl", {bus.cmd_ready, bus.buf_read_addr_valid, bus.out_valid,
                           bus.out_last, bus.busy, bus.done}, 0);
        chk("reset_data", bus.out_data, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("ready_at_release", bus.cmd_ready, 0);
        step();
        chk("ready_after_release", bus.cmd_ready, 1);

        // T1: basic burst with exact cycle timing
        clear_obs(); dc = done_cnt;
        send_cmd(12'h010, 4, t);
        wait_done(50, 1'b0, dc);
        check_cmd("T1", 12'h010, 4);
        chk("T1 addr0_cyc", at_i(addr_cyc_q, 0), t + 1);
        chk("T1 addr3_cyc", at_i(addr_cyc_q, 3), t + 4);
        chk("T1 beat0_cyc", at_i(beat_cyc_q, 0), t + 6);
        chk("T1 beat3_cyc", at_i(beat_cyc_q, 3), t + 9);
        chk("T1 done_cyc", done_cyc, t + 10);
        repeat (3) step();
        chk("T1 done_pulse", bus.done, 0);
        chk("T1 done_count", done_cnt - dc, 1);

        // T2: address wrap
        clear_obs(); dc = done_cnt;
        send_cmd(12'h7FE, 4, t);
        wait_done(50, 1'b0, dc);
        check_cmd("T2", 12'h7FE, 4);

        // T3: downstream stall, credits limit issue to FIFO depth
        clear_obs(); dc = done_cnt;
        bus.out_ready = 1'b0;
        send_cmd(12'h200, 20, t);
        repeat (29) step();
        chk("T3 stalled_addrs", addr_q.size(), DEPTH);
        chk("T3 max_outstanding", max_out, DEPTH);
        chk("T3 busy", bus.busy, 1);
        wait_done(200, 1'b0, dc);
        check_cmd("T3", 12'h200, 20);
        repeat (5) step();
        chk("T3 done_once", done_cnt - dc, 1);
        chk("T3 stable", stab_err, 0);

        // T4: empty command
        clear_obs(); dc = done_cnt;
        send_cmd(12'h123, 0, t);
        chk("T4 done", bus.done, 1);
        chk("T4 cmd_ready", bus.cmd_ready, 1);
        step();
        chk("T4 done_pulse", bus.done, 0);
        repeat (6) step();
        chk("T4 no_addr", addr_q.size(), 0);
        chk("T4 no_beat", beat_q.size(), 0);
        chk("T4 done_count", done_cnt - dc, 1);
        chk("T4 busy", bus.busy, 0);

        // T5: random base and random backpressure
        clear_obs(); dc = done_cnt;
        b = $urandom_range(0, NLINES - 1);
        send_cmd(b, 100, t);
        wait_done(3000, 1'b1, dc);
        check_cmd("T5", b, 100);
        chk("T5 stable", stab_err, 0);
        chk("T5 zero_idle", zero_err, 0);
        chk("T5 credit_bound", (max_out <= DEPTH), 1);

        // T6: reset mid-burst, then a clean command
        clear_obs(); dc = done_cnt;
        send_cmd(12'h300, 20, t);
        for (int k = 0; k < 20 && addr_q.size() < 3; k++) begin
            @(negedge clk);
            #1;
        end
        chk("T6 pre_reset_addrs", addr_q.size(), 3);
        rst = 1'b1;
        #1;
        chk("T6 reset_ctrl", {bus.cmd_ready, bus.buf_read_addr_valid, bus.out_valid,
                              bus.out_last, bus.busy, bus.done}, 0);
        chk("T6 reset_data", bus.out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) step();
        chk("T6 no_beat", beat_q.size(), 0);
        chk("T6 no_new_addr", addr_q.size(), 3);
        chk("T6 no_done", done_cnt, dc);
        chk("T6 idle", {bus.busy, bus.out_valid}, 0);
        chk("T6 zero_idle", zero_err, 0);
        clear_obs(); dc = done_cnt;
        send_cmd(12'h100, 2, t);
        wait_done(50, 1'b0, dc);
        check_cmd("T6b", 12'h100, 2);
        chk("T6b done_cyc", done_cyc, t + 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
